// File: rtl/trx_sequencer_pkg.sv
// trx_seq_pkg: shared types for the half-duplex frame sequencer.
//   - seq_state_t : 3-bit FSM state (IDLE, TX_RUN, TX_DRAIN, TURNAROUND, RX_RUN = 0..4)
//   - ST_*        : raw state encodings, also visible on outState
//   - cnt_w_for() : smallest counter width able to hold max_bits
package trx_seq_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_TX_RUN   = 3'd1;
  localparam logic [2:0] ST_TX_DRAIN = 3'd2;
  localparam logic [2:0] ST_TURN     = 3'd3;
  localparam logic [2:0] ST_RX_RUN   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_TX_RUN   = ST_TX_RUN,
    S_TX_DRAIN = ST_TX_DRAIN,
    S_TURN     = ST_TURN,
    S_RX_RUN   = ST_RX_RUN
  } seq_state_t;

  // Width needed so that a counter can reach max_bits without wrapping.
  function automatic int cnt_w_for(input int max_bits);
    int w;
    w = 1;
    while ((1 << w) <= max_bits) w++;
    return w;
  endfunction

endpackage

// File: rtl/trx_sequencer_if.sv
// trx_sequencer_if: control/status bundle between the sequencer and the
// transceiver datapath (inFIFO, coder, RX chain, outFIFO).
//   master : drives the in* requests/flags, observes the out* strobes/status
//   slave  : the sequencer side
interface trx_sequencer_if
  import trx_seq_pkg::*;
#(
  parameter int CNT_W = 8
);
  logic             inTxStart;
  logic             inRxStart;
  logic             inAbort;
  logic             inFifoEmpty;
  logic             inCoderReady;
  logic             inCdrFlag;
  logic             inOutFifoFull;
  logic             outFifoReadEnable;
  logic             outCoderEmpty;
  logic             outRxEnable;
  logic             outOutFifoWriteEnable;
  logic [CNT_W-1:0] outBitCount;
  seq_state_t       outState;
  logic             outBusy;
  logic             outDone;
  logic             outOverflow;

  modport master (
    output inTxStart, inRxStart, inAbort, inFifoEmpty, inCoderReady,
           inCdrFlag, inOutFifoFull,
    input  outFifoReadEnable, outCoderEmpty, outRxEnable,
           outOutFifoWriteEnable, outBitCount, outState, outBusy, outDone,
           outOverflow
  );

  modport slave (
    input  inTxStart, inRxStart, inAbort, inFifoEmpty, inCoderReady,
           inCdrFlag, inOutFifoFull,
    output outFifoReadEnable, outCoderEmpty, outRxEnable,
           outOutFifoWriteEnable, outBitCount, outState, outBusy, outDone,
           outOverflow
  );
endinterface

// File: rtl/trx_sequencer_seq_timer.sv
// seq_timer: loadable down-counter that stops at zero.
//   i_clk/i_rst : clock, synchronous active-high reset (count -> 0)
//   i_load      : load i_load_val (wins over i_en)
//   i_en        : decrement by one while non-zero
//   o_zero      : count == 0
module seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)                     r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/trx_sequencer.sv
// trx_sequencer: half-duplex frame sequencer sharing one datapath clock
// between the TX chain (inFIFO -> coder) and the RX chain (-> outFIFO).
//   inClock/inReset : clock, synchronous active-high reset
//   bus (slave)     : start/abort requests, FIFO/coder/CDR flags in;
//                     read/write strobes, coder-empty, RX enable, bit count,
//                     state, busy, done pulse, sticky overflow out
// One timer serves the drain, turnaround and RX idle timeout; it is
// reloaded on every state change that needs it.
module trx_sequencer
  import trx_seq_pkg::*;
#(
  parameter int MAX_BITS     = 128,
  parameter int CNT_W        = cnt_w_for(MAX_BITS),
  parameter int DRAIN_CYCLES = 16,
  parameter int TURN_CYCLES  = 12,
  parameter int RX_TIMEOUT   = 64
) (
  input  logic inClock,
  input  logic inReset,
  trx_sequencer_if.slave bus
);
  localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(MAX_BITS - 1);
  localparam logic [CNT_W-1:0] LP_DRAIN = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_TURN  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_RXTO  = CNT_W'(RX_TIMEOUT - 1);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_done;

  logic             w_tx_go, w_rd, w_underrun, w_wr, w_drop, w_abort;
  logic             w_last, w_tx_end, w_rx_end;
  logic             w_tmr_load, w_tmr_en, w_tmr_zero;
  logic [CNT_W-1:0] w_tmr_val;

  // Abort only matters while a frame is actually moving data or draining.
  assign w_abort    = bus.inAbort & ((r_state == S_TX_RUN) |
                                     (r_state == S_TX_DRAIN) |
                                     (r_state == S_RX_RUN));
  assign w_tx_go    = bus.inTxStart & ~bus.inFifoEmpty;
  assign w_rd       = (r_state == S_TX_RUN) & bus.inCoderReady &
                      ~bus.inFifoEmpty & ~bus.inAbort;
  assign w_underrun = (r_state == S_TX_RUN) & bus.inCoderReady &
                      bus.inFifoEmpty & ~bus.inAbort;
  assign w_wr       = (r_state == S_RX_RUN) & bus.inCdrFlag &
                      ~bus.inOutFifoFull & ~bus.inAbort;
  assign w_drop     = (r_state == S_RX_RUN) & bus.inCdrFlag &
                      bus.inOutFifoFull & ~bus.inAbort;
  // This strobe brings the count to MAX_BITS.
  assign w_last     = (r_cnt == LP_LAST);
  assign w_tx_end   = (w_rd & w_last) | w_underrun;
  assign w_rx_end   = (w_wr & w_last) | (~bus.inCdrFlag & w_tmr_zero);

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_en   = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      S_IDLE: begin
        if (!w_tx_go && bus.inRxStart) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = LP_RXTO;
        end
      end
      S_TX_RUN: begin
        if (w_abort) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = LP_TURN;
        end else if (w_tx_end) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = LP_DRAIN;
        end
      end
      S_TX_DRAIN: begin
        if (w_abort || w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = LP_TURN;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      S_RX_RUN: begin
        if (w_abort || w_rx_end) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = LP_TURN;
        end else if (bus.inCdrFlag) begin
          // any recovered bit, kept or dropped, restarts the idle window
          w_tmr_load = 1'b1;
          w_tmr_val  = LP_RXTO;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      S_TURN:  w_tmr_en = 1'b1;
      default: ;
    endcase
  end

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (inClock),
    .i_rst      (inReset),
    .i_load     (w_tmr_load),
    .i_en       (w_tmr_en),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge inClock) begin
    if (inReset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // TX has priority; RX is taken when TX cannot start.
          if (w_tx_go) begin
            r_state <= S_TX_RUN;
            r_cnt   <= '0;
          end else if (bus.inRxStart) begin
            r_state <= S_RX_RUN;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        S_TX_RUN: begin
          if (w_abort) begin
            r_state <= S_TURN;
          end else begin
            if (w_rd)     r_cnt   <= r_cnt + 1'b1;
            if (w_tx_end) r_state <= S_TX_DRAIN;
          end
        end
        S_TX_DRAIN: begin
          if (w_abort || w_tmr_zero) r_state <= S_TURN;
        end
        S_RX_RUN: begin
          if (w_abort) begin
            r_state <= S_TURN;
          end else begin
            if (w_wr)     r_cnt   <= r_cnt + 1'b1;
            if (w_drop)   r_ovf   <= 1'b1;
            if (w_rx_end) r_state <= S_TURN;
          end
        end
        S_TURN: begin
          if (w_tmr_zero) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are combinational so the coder/CDR see zero-latency responses.
  assign bus.outFifoReadEnable     = w_rd;
  assign bus.outCoderEmpty         = (r_state == S_TX_RUN) ? bus.inFifoEmpty : 1'b1;
  assign bus.outRxEnable           = (r_state == S_RX_RUN);
  assign bus.outOutFifoWriteEnable = w_wr;
  assign bus.outBitCount           = r_cnt;
  assign bus.outState              = r_state;
  assign bus.outBusy               = (r_state != S_IDLE);
  assign bus.outDone               = r_done;
  assign bus.outOverflow           = r_ovf;
endmodule

// File: tb/tb_trx_sequencer.sv
module tb_trx_sequencer;
  import trx_seq_pkg::*;

  localparam int MAXB  = 128;
  localparam int DRAIN = 16;
  localparam int TURN  = 12;
  localparam int RXTO  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trx_sequencer_if #(.CNT_W(8)) bus ();

  trx_sequencer #(.MAX_BITS(MAXB), .CNT_W(8), .DRAIN_CYCLES(DRAIN),
                  .TURN_CYCLES(TURN), .RX_TIMEOUT(RXTO)) dut (
    .inClock (clk),
    .inReset (rst),
    .bus     (bus)
  );

  // expected frame summary; -1 = not checked
  typedef struct {
    int bits; int drain; int turn; int ovf; int idle; int rem;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int passes = 0;
  int fifo_cnt = 0;
  int rd_seen = 0;
  int model_ovf = 0;
  bit seen_done = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
  endtask

  // one clock: sample at negedge, drive new inputs 1 unit after posedge
  task automatic step();
    @(negedge clk);
    if (bus.outFifoReadEnable) begin fifo_cnt--; rd_seen++; end
    if (bus.outDone) seen_done = 1;
    @(posedge clk);
    #1;
    bus.inFifoEmpty   = (fifo_cnt == 0);
    bus.inTxStart     = 0;
    bus.inRxStart     = 0;
    bus.inAbort       = 0;
    bus.inCdrFlag     = 0;
    bus.inOutFifoFull = 0;
    bus.inCoderReady  = 0;
  endtask

  // starts pulsed during turnaround must be ignored
  task automatic poke_turn();
    if (int'(bus.outState) == 3 && $urandom_range(0, 2) == 0) begin
      bus.inTxStart = 1;
      bus.inRxStart = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!seen_done && n < 3000) begin poke_turn(); step(); n++; end
    chk({nm, "_done_seen"}, int'(seen_done), 1);
  endtask

  // TX frame of n inFIFO entries; abort_at>0 aborts on that read attempt
  task automatic tx_frame(input int n, input int abort_at, input bit with_rx,
                          input int period);
    exp_t e;
    int nb, cyc, n_to;
    bit aborted;
    nb = (abort_at > 0) ? abort_at - 1 : ((n < MAXB) ? n : MAXB);
    e.bits = nb; e.drain = (abort_at > 0) ? 0 : DRAIN; e.turn = TURN;
    e.ovf = model_ovf; e.idle = -1; e.rem = n - nb;
    q.push_back(e);
    fifo_cnt = n; bus.inFifoEmpty = (n == 0);
    seen_done = 0; rd_seen = 0; aborted = 0; cyc = 0; n_to = 0;
    bus.inTxStart = 1; bus.inRxStart = with_rx;
    step();
    while (!seen_done && n_to < 3000) begin
      cyc++;
      bus.inCoderReady = (period > 0) ? (cyc % period == 0)
                                      : ($urandom_range(0, 2) == 0);
      if (abort_at > 0 && !aborted && int'(bus.outState) == 1 &&
          bus.inCoderReady && fifo_cnt > 0 && rd_seen == abort_at - 1) begin
        bus.inAbort = 1; aborted = 1;
      end
      poke_turn();
      step(); n_to++;
    end
    chk("tx_done_seen", int'(seen_done), 1);
  endtask

  // RX frame: full_mode 0 none, 1 random, 2 flags 15..17 full
  task automatic rx_frame(input int nflags, input int abort_idx, input bit with_tx,
                          input int full_mode, input int max_gap);
    exp_t e;
    bit full_a[$];
    int wr, ov, hit_cap;
    wr = 0; ov = 0; hit_cap = 0;
    for (int i = 0; i < nflags; i++) begin
      bit f;
      f = (full_mode == 1) ? ($urandom_range(0, 3) == 0)
        : (full_mode == 2) ? (i >= 14 && i <= 16) : 1'b0;
      if (i == abort_idx) f = 0;
      full_a.push_back(f);
    end
    for (int i = 0; i < nflags; i++) begin
      if (i == abort_idx || wr == MAXB) break;
      if (full_a[i]) ov = 1; else wr++;
    end
    hit_cap = (wr == MAXB);
    e.bits = wr; e.drain = 0; e.turn = TURN; e.ovf = ov;
    e.idle = (abort_idx >= 0 || hit_cap) ? -1 : RXTO; e.rem = -1;
    q.push_back(e);
    model_ovf = ov;
    if (with_tx) begin fifo_cnt = 0; bus.inFifoEmpty = 1; end
    seen_done = 0;
    bus.inRxStart = 1; bus.inTxStart = with_tx;
    step();
    for (int i = 0; i < nflags; i++) begin
      repeat ($urandom_range(0, max_gap)) step();
      bus.inCdrFlag = 1; bus.inOutFifoFull = full_a[i];
      if (i == abort_idx) bus.inAbort = 1;
      step();
      if (i == abort_idx) break;
    end
    wait_done("rx");
  endtask

  // scoreboard monitor: per-cycle output rules plus per-frame summary
  initial begin
    int prev_st, st, str, drn, trn, idle, obs_idle;
    exp_t e;
    prev_st = 0; str = 0; drn = 0; trn = 0; idle = 0; obs_idle = -1;
    forever begin
      @(negedge clk);
      st = int'(bus.outState);
      if (rst) begin
        prev_st = 0; str = 0; drn = 0; trn = 0; idle = 0; obs_idle = -1;
      end else begin
        chk("busy", int'(bus.outBusy), int'(st != 0));
        if (st == 1) begin
          chk("tx_read", int'(bus.outFifoReadEnable),
              int'(bus.inCoderReady & ~bus.inFifoEmpty & ~bus.inAbort));
          chk("tx_coder_empty", int'(bus.outCoderEmpty), int'(bus.inFifoEmpty));
          chk("tx_rx_en", int'(bus.outRxEnable), 0);
          chk("tx_write", int'(bus.outOutFifoWriteEnable), 0);
        end else if (st == 4) begin
          chk("rx_write", int'(bus.outOutFifoWriteEnable),
              int'(bus.inCdrFlag & ~bus.inOutFifoFull & ~bus.inAbort));
          chk("rx_rx_en", int'(bus.outRxEnable), 1);
          chk("rx_read", int'(bus.outFifoReadEnable), 0);
          chk("rx_coder_empty", int'(bus.outCoderEmpty), 1);
        end else begin
          chk("quiet_read", int'(bus.outFifoReadEnable), 0);
          chk("quiet_write", int'(bus.outOutFifoWriteEnable), 0);
          chk("quiet_rx_en", int'(bus.outRxEnable), 0);
          chk("quiet_coder_empty", int'(bus.outCoderEmpty), 1);
        end
        if (bus.outFifoReadEnable || bus.outOutFifoWriteEnable) str++;
        if (st == 2) drn++;
        if (st == 3) trn++;
        if (st == 4) begin
          if (prev_st != 4) idle = 0;
          if (bus.inCdrFlag) idle = 0; else idle++;
        end
        if (st == 3 && prev_st == 4) obs_idle = idle;
        if (bus.outDone) begin
          chk("done_on_turn_exit", int'(prev_st == 3 && st == 0), 1);
          if (q.size() == 0) begin
            checks++;
            $display("FAIL done_unexpected: got a done pulse, expected no frame");
          end else begin
            e = q.pop_front();
            chk("frame_bitcount", int'(bus.outBitCount), e.bits);
            chk("frame_strobes", str, e.bits);
            chk("frame_drain_cycles", drn, e.drain);
            chk("frame_turn_cycles", trn, e.turn);
            chk("frame_overflow", int'(bus.outOverflow), e.ovf);
            if (e.idle >= 0) chk("rx_timeout_cycles", obs_idle, e.idle);
            if (e.rem >= 0) chk("fifo_remaining", fifo_cnt, e.rem);
          end
          str = 0; drn = 0; trn = 0; obs_idle = -1;
        end
        prev_st = st;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_state(input string nm);
    chk({nm, "_state"}, int'(bus.outState), 0);
    chk({nm, "_coder_empty"}, int'(bus.outCoderEmpty), 1);
    chk({nm, "_bitcount"}, int'(bus.outBitCount), 0);
    chk({nm, "_overflow"}, int'(bus.outOverflow), 0);
    chk({nm, "_busy"}, int'(bus.outBusy), 0);
    chk({nm, "_done"}, int'(bus.outDone), 0);
    chk({nm, "_rx_en"}, int'(bus.outRxEnable), 0);
    chk({nm, "_strobes"}, int'(bus.outFifoReadEnable | bus.outOutFifoWriteEnable), 0);
  endtask

  initial begin
    bus.inTxStart = 0; bus.inRxStart = 0; bus.inAbort = 0; bus.inFifoEmpty = 1;
    bus.inCoderReady = 0; bus.inCdrFlag = 0; bus.inOutFifoFull = 0;
    rst = 1;
    repeat (3) step();
    chk_reset_state("reset");
    rst = 0;
    step();

    // directed scenarios
    tx_frame(10, 0, 0, 4);              // normal TX, ready every 4th cycle
    tx_frame(200, 0, 0, 0);             // length cap -> 72 left
    rx_frame(20, -1, 0, 2, 5);          // overflow on flags 15..17, timeout exit
    chk("ovf_sticky_idle", int'(bus.outOverflow), 1);
    tx_frame(10, 5, 0, 0);              // abort on 5th read, ovf still sticky
    tx_frame(8, 0, 1, 0);               // TX+RX with data -> TX
    rx_frame(5, -1, 1, 0, 5);           // TX+RX with empty FIFO -> RX
    rx_frame(10, 6, 0, 1, 3);           // abort coincident with a flag
    rx_frame(140, -1, 0, 0, 0);         // RX length cap

    // requests that must be ignored
    fifo_cnt = 0; bus.inFifoEmpty = 1; bus.inTxStart = 1;
    step(); step();
    chk("tx_empty_ignored", int'(bus.outState), 0);
    bus.inAbort = 1;
    step(); step();
    chk("abort_idle_ignored", int'(bus.outState), 0);

    // randomized frames
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        int n, ab;
        n = $urandom_range(1, 60);
        ab = (n >= 5 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
        tx_frame(n, ab, 1'($urandom_range(0, 1)), 0);
      end else begin
        int nf, ai;
        nf = $urandom_range(1, 30);
        ai = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nf - 1) : -1;
        rx_frame(nf, ai, 0, 1, 5);
      end
    end

    // reset in the middle of an RX frame
    bus.inRxStart = 1; step();
    bus.inCdrFlag = 1; bus.inOutFifoFull = 1; step();
    bus.inCdrFlag = 1; step();
    step();
    chk("mid_rx_state", int'(bus.outState), 4);
    chk("mid_rx_overflow", int'(bus.outOverflow), 1);
    chk("mid_rx_bitcount", int'(bus.outBitCount), 1);
    rst = 1; bus.inCdrFlag = 1;
    step();
    rst = 0;
    chk_reset_state("mid_reset");
    model_ovf = 0;

    repeat (5) step();
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/trx_sequencer.md
Name: trx_sequencer

Overview:
- Half-duplex frame sequencer for the transceiver.
- It shares the single datapath clock between the TX chain (inFIFO → MSK coder) and the RX chain (decoder → CORDIC → CDR → outFIFO).
- TX: generates the inFIFO read strobe and coder empty indication, flushes the coder, and enforces a turnaround gap.
- RX: gates the RX chain, writes recovered bits into outFIFO with overflow detection, and ends the frame on bit count or timeout.

Parameters:
- CNT_W, 8, width of the bit counter and all internal timers.
- MAX_BITS, 128, maximum bits per frame, TX and RX. Must be 1..2^CNT_W-1.
- DRAIN_CYCLES, 16, cycles the coder is held empty after the last TX bit. Must be ≥1.
- TURN_CYCLES, 12, TX/RX turnaround guard length in cycles. Must be ≥1.
- RX_TIMEOUT, 64, idle cycles without a CDR flag that end RX. Must be ≥1.

Ports:
- inClock  in  1  system clock.
- inReset  in  1  reset, synchronous, active-high.
- inTxStart  in  1  single-cycle TX frame request.
- inRxStart  in  1  single-cycle RX frame request.
- inAbort  in  1  terminate the current frame.
- inFifoEmpty  in  1  inFIFO empty flag.
- inCoderReady  in  1  coder requests the next bit.
- inCdrFlag  in  1  CDR recovered-bit valid.
- inOutFifoFull  in  1  outFIFO full flag.
- outFifoReadEnable  out  1  inFIFO read strobe.
- outCoderEmpty  out  1  coder empty input (1 = no data).
- outRxEnable  out  1  enables decoder/CORDIC/CDR chain.
- outOutFifoWriteEnable  out  1  outFIFO write strobe.
- outBitCount  out  CNT_W  bits transferred in the current or last frame.
- outState  out  3  current state encoding.
- outBusy  out  1  state != IDLE.
- outDone  out  1  one-cycle pulse on the TURNAROUND→IDLE transition.
- outOverflow  out  1  sticky; RX bit dropped because outFIFO was full.

Behaviour:
- Reset (sync, active-high, wins over every other input):
  - state = IDLE, all counters = 0.
  - All outputs 0, except outCoderEmpty = 1.
- States: IDLE, TX_RUN, TX_DRAIN, TURNAROUND, RX_RUN (3-bit encoding, values 0..4 in that order).
- IDLE:
  - outCoderEmpty = 1, outRxEnable = 0, no strobes.
  - inTxStart & !inFifoEmpty → TX_RUN, and outBitCount cleared.
  - inTxStart & inFifoEmpty → request ignored, stay IDLE.
  - inRxStart → RX_RUN, and outBitCount and outOverflow cleared.
  - TX and RX start in the same cycle → TX wins if its start condition holds; otherwise RX is taken.
- TX_RUN:
  - outFifoReadEnable = inCoderReady & !inFifoEmpty. Combinational, same cycle as inCoderReady; zero latency.
  - outCoderEmpty = inFifoEmpty.
  - Each read increments outBitCount.
  - Exit to TX_DRAIN when a read brings the count to MAX_BITS (that read is issued).
  - Also exit to TX_DRAIN when inCoderReady & inFifoEmpty (underrun, treated as end of frame).
  - Timer loaded with DRAIN_CYCLES-1 on exit.
- TX_DRAIN:
  - outCoderEmpty = 1, no reads.
  - Timer counts down; at 0 → TURNAROUND, timer loaded with TURN_CYCLES-1.
- RX_RUN:
  - outRxEnable = 1.
  - outOutFifoWriteEnable = inCdrFlag & !inOutFifoFull; each write increments outBitCount.
  - inCdrFlag & inOutFifoFull → bit dropped, outOverflow set next cycle, count not incremented.
  - Idle timer is reloaded to RX_TIMEOUT-1 on every inCdrFlag and decrements otherwise.
  - Exit to TURNAROUND when the count reaches MAX_BITS or the idle timer reaches 0 with no flag.
  - outRxEnable drops in the first TURNAROUND cycle.
- TURNAROUND:
  - All enables and strobes 0, outCoderEmpty = 1.
  - At timer 0 → IDLE, with outDone = 1 for exactly that one cycle.
  - inTxStart/inRxStart are ignored here; no queuing.
- inAbort in TX_RUN, TX_DRAIN or RX_RUN:
  - Strobes are masked combinationally in the same cycle.
  - Next state is TURNAROUND (full TURN_CYCLES); outBitCount holds its value.
- inAbort in IDLE or TURNAROUND: no effect.
- outBitCount holds after a frame until the next accepted start. It never wraps, because the count is bounded by MAX_BITS.
- Start pulses arriving while outBusy = 1 are ignored.

Decomposition:
- Package trx_seq_pkg holds:
  - the state enum (3-bit typedef);
  - localparam state encodings;
  - a function computing the default CNT_W from MAX_BITS.
- One sub-module, seq_timer: CNT_W-bit loadable down-counter with load, enable and a zero flag. It is shared for the drain, turnaround and RX timeout by reloading per state.

Test Plan:
- TX normal: 10 entries in inFIFO, inTxStart, inCoderReady every 4th cycle → 10 read strobes, each coincident with inCoderReady.
  - After the 11th ready (FIFO empty): 16 TX_DRAIN cycles, 12 TURNAROUND cycles, outDone pulse, outBitCount = 10.
- TX length cap: 200 entries, MAX_BITS = 128 → exactly 128 reads, then TX_DRAIN; 72 entries remain in inFIFO.
- RX with overflow: inRxStart, 20 inCdrFlag pulses, inOutFifoFull high for flags 15–17 → 17 writes, outOverflow = 1 and sticky.
  - Exit via timeout 64 cycles after the last flag; outBitCount = 17.
- Abort: inAbort on the 5th TX read cycle → no strobe that cycle, TURNAROUND next, outBitCount = 4, outDone after 12 cycles.
- Contention: inTxStart and inRxStart together with a non-empty FIFO → TX_RUN. Repeated with an empty FIFO → RX_RUN.
  - Start during TURNAROUND → ignored.
- Reset mid-frame: inReset asserted in RX_RUN → next edge gives state IDLE (0), all strobes 0, outCoderEmpty = 1, outBitCount = 0, outOverflow = 0.
